// File: rtl/prim_fifo_burst_reader.sv
// prim_fifo_burst_reader: drains a valid/ready FIFO in bounded bursts.
// A burst starts when occupancy reaches a threshold or when a non-empty
// FIFO has waited long enough; popped words leave through a registered
// output stage tagged with first/last framing.
module prim_fifo_burst_reader #(
    parameter int unsigned Width    = 16,
    parameter int unsigned DepthW   = 3,
    parameter int unsigned MaxBurst = 4,
    parameter int unsigned TimeoutW = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                enable_i,
    input  logic [DepthW-1:0]   threshold_i,
    input  logic [TimeoutW-1:0] timeout_i,
    input  logic                fifo_rvalid_i,
    output logic                fifo_rready_o,
    input  logic [Width-1:0]    fifo_rdata_i,
    input  logic [DepthW-1:0]   fifo_depth_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [Width-1:0]    out_data_o,
    output logic                out_first_o,
    output logic                out_last_o,
    output logic                busy_o
);

    localparam int unsigned FetchW = $clog2(MaxBurst + 1);
    // min() is evaluated wide enough to hold both the occupancy and the cap
    localparam int unsigned MinW   = (DepthW > FetchW) ? DepthW : FetchW;
    localparam logic [MinW-1:0] MaxBurstW = MinW'(MaxBurst);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e              state_q,      state_d;
    logic [FetchW-1:0]   fetch_left_q, fetch_left_d;
    logic [TimeoutW-1:0] timer_q,      timer_d;
    logic                first_pend_q, first_pend_d;
    logic                out_valid_q,  out_valid_d;
    logic [Width-1:0]    out_data_q,   out_data_d;
    logic                out_first_q,  out_first_d;
    logic                out_last_q,   out_last_d;

    logic            depth_nz;
    logic            thr_hit;
    logic            to_hit;
    logic            start;
    logic [MinW-1:0] depth_ext;
    logic [MinW-1:0] burst_len;
    logic            pop_ready;
    logic            pop;
    logic            accept;

    // Start decision: occupancy threshold or idle-wait timeout, each disabled by 0
    assign depth_nz  = (fifo_depth_i != '0);
    assign thr_hit   = (threshold_i != '0) && (fifo_depth_i >= threshold_i);
    assign to_hit    = (timeout_i != '0) && (timer_q >= timeout_i);
    assign start     = (state_q == IDLE) && enable_i && depth_nz && (thr_hit || to_hit);

    // Burst length is the current occupancy capped at MaxBurst
    assign depth_ext = MinW'(fifo_depth_i);
    assign burst_len = (depth_ext < MaxBurstW) ? depth_ext : MaxBurstW;

    // Pop only when the output register is free or draining this cycle;
    // a clear (or reset) in the same cycle suppresses the pop.
    assign pop_ready = (state_q == BURST) && (fetch_left_q != '0) &&
                       (!out_valid_q || out_ready_i) && !clr_i && !rst_i;
    assign pop       = fifo_rvalid_i && pop_ready;
    assign accept    = out_valid_q && out_ready_i;

    // Next-state logic for the FSM, counters and output register
    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch can leave a
        // signal unassigned and infer a latch.
        state_d      = state_q;
        fetch_left_d = fetch_left_q;
        timer_d      = timer_q;
        first_pend_d = first_pend_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_first_d  = out_first_q;
        out_last_d   = out_last_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = BURST;
                    fetch_left_d = FetchW'(burst_len);
                    timer_d      = '0;
                    first_pend_d = 1'b1;
                end else if (enable_i && depth_nz) begin
                    // Saturate rather than wrap so a long wait never looks short
                    if (timer_q != '1) begin
                        timer_d = timer_q + 1'b1;
                    end
                end else begin
                    timer_d = '0;
                end
            end
            BURST: begin
                timer_d = '0;
                if (pop) begin
                    fetch_left_d = fetch_left_q - 1'b1;
                    first_pend_d = 1'b0;
                end
                // The last word leaving the output stage ends the burst
                if (accept && out_last_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Output stage: load on pop, drop valid on accept, otherwise hold
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = fifo_rdata_i;
            out_first_d = first_pend_q;
            out_last_d  = (fetch_left_q == FetchW'(1));
        end else if (accept) begin
            out_valid_d = 1'b0;
        end

        // Soft clear returns everything to the reset state
        if (clr_i) begin
            state_d      = IDLE;
            fetch_left_d = '0;
            timer_d      = '0;
            first_pend_d = 1'b0;
            out_valid_d  = 1'b0;
            out_data_d   = '0;
            out_first_d  = 1'b0;
            out_last_d   = 1'b0;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            fetch_left_q <= '0;
            timer_q      <= '0;
            first_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_first_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            fetch_left_q <= fetch_left_d;
            timer_q      <= timer_d;
            first_pend_q <= first_pend_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_first_q  <= out_first_d;
            out_last_q   <= out_last_d;
        end
    end

    assign fifo_rready_o = pop_ready;
    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign out_first_o   = out_first_q;
    assign out_last_o    = out_last_q;
    assign busy_o        = (state_q == BURST);

endmodule

// File: tb/tb_prim_fifo_burst_reader.sv
// Testbench for prim_fifo_burst_reader: a queue-based FIFO feeds the DUT and
// a burst-level reference model predicts busy, pops, valid and each framed word.
module tb_prim_fifo_burst_reader;

    localparam int W   = 16;
    localparam int DW  = 3;
    localparam int MB  = 4;
    localparam int TW  = 8;
    localparam int CAP = 7;

    logic          clk = 1'b0;
    logic          rst_i, clr_i, enable_i;
    logic [DW-1:0] threshold_i;
    logic [TW-1:0] timeout_i;
    logic          fifo_rvalid_i, fifo_rready_o;
    logic [W-1:0]  fifo_rdata_i;
    logic [DW-1:0] fifo_depth_i;
    logic          out_valid_o, out_ready_i, out_first_o, out_last_o, busy_o;
    logic [W-1:0]  out_data_o;

    prim_fifo_burst_reader #(.Width(W), .DepthW(DW), .MaxBurst(MB), .TimeoutW(TW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .clr_i        (clr_i),
        .enable_i     (enable_i),
        .threshold_i  (threshold_i),
        .timeout_i    (timeout_i),
        .fifo_rvalid_i(fifo_rvalid_i),
        .fifo_rready_o(fifo_rready_o),
        .fifo_rdata_i (fifo_rdata_i),
        .fifo_depth_i (fifo_depth_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_first_o  (out_first_o),
        .out_last_o   (out_last_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // FIFO contents (head at index 0) and the burst the model expects next
    logic [W-1:0] fq[$];
    logic [W-1:0] m_burst[$];
    bit           m_busy, m_valid;
    int           m_left, m_len, m_acc, m_wait;
    bit           stall_prev;
    logic [W-1:0] sv_data;
    logic         sv_first, sv_last;
    bit           pop_pend, push_req;
    logic [W-1:0] push_data;
    int           cyc, pops, acc_words, acc_firsts, acc_lasts;
    int           nonempty_cyc, rise_cyc, prev_d;
    bit           busy_prev;

    task automatic drive_fifo();
        fifo_rvalid_i = (fq.size() != 0);
        fifo_rdata_i  = (fq.size() != 0) ? fq[0] : '0;
        fifo_depth_i  = DW'(fq.size());
    endtask

    // Called at the falling edge: compare DUT with the model, then advance the model
    task automatic evaluate();
        int d;
        bit exp_rr, accept, pop, start;
        d = fq.size();
        cyc++;
        if (d != 0 && prev_d == 0) nonempty_cyc = cyc;
        if (busy_o && !busy_prev) rise_cyc = cyc;
        busy_prev = busy_o;
        prev_d    = d;

        exp_rr = m_busy && (m_left != 0) && (!m_valid || out_ready_i) && !clr_i && !rst_i;
        accept = m_valid && out_ready_i;

        if (!rst_i) begin
            check("busy", 32'(busy_o), 32'(m_busy));
            check("rready", 32'(fifo_rready_o), 32'(exp_rr));
            check("out_valid", 32'(out_valid_o), 32'(m_valid));
            if (stall_prev) begin
                check("stall_data", 32'(out_data_o), 32'(sv_data));
                check("stall_first", 32'(out_first_o), 32'(sv_first));
                check("stall_last", 32'(out_last_o), 32'(sv_last));
            end
            if (accept && m_acc < m_len) begin
                check("word_data", 32'(out_data_o), 32'(m_burst[m_acc]));
                check("word_first", 32'(out_first_o), 32'(m_acc == 0));
                check("word_last", 32'(out_last_o), 32'(m_acc == m_len - 1));
            end
            if (accept) begin
                acc_words++;
                if (out_first_o) acc_firsts++;
                if (out_last_o)  acc_lasts++;
            end
        end

        pop        = exp_rr && (d != 0);
        stall_prev = m_valid && !out_ready_i && !clr_i && !rst_i;
        sv_data    = out_data_o;
        sv_first   = out_first_o;
        sv_last    = out_last_o;

        if (rst_i || clr_i) begin
            m_busy = 0; m_valid = 0; m_left = 0; m_wait = 0; m_acc = 0; m_len = 0;
            m_burst.delete();
            pop = 0;
        end else if (!m_busy) begin
            start = enable_i && (d != 0) &&
                    ((threshold_i != 0 && d >= int'(threshold_i)) ||
                     (timeout_i != 0 && m_wait >= int'(timeout_i)));
            if (start) begin
                m_busy = 1;
                m_len  = (d < MB) ? d : MB;
                m_left = m_len;
                m_acc  = 0;
                m_wait = 0;
                m_burst.delete();
                for (int i = 0; i < m_len; i++) m_burst.push_back(fq[i]);
            end else if (enable_i && d != 0) begin
                if (m_wait < (1 << TW) - 1) m_wait++;
            end else begin
                m_wait = 0;
            end
        end else begin
            m_wait = 0;
            if (accept) begin
                m_acc++;
                if (m_acc == m_len) m_busy = 0;
            end
            if (pop) begin
                m_left--;
                m_valid = 1;
            end else if (accept) begin
                m_valid = 0;
            end
        end
        if (pop) pops++;
        pop_pend = pop;
    endtask

    // Called just after the rising edge: perform the pop/push the edge committed
    task automatic apply();
        if (pop_pend) void'(fq.pop_front());
        if (push_req && fq.size() < CAP) fq.push_back(push_data);
        push_req = 0;
        pop_pend = 0;
        drive_fifo();
    endtask

    task automatic tick();
        @(negedge clk);
        evaluate();
        @(posedge clk);
        #1;
        apply();
    endtask

    task automatic push_word(input logic [W-1:0] data);
        push_req  = 1;
        push_data = data;
        tick();
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int n;
        n = 0;
        while ((busy_o || out_valid_o || fq.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(fq.size()) + 32'(busy_o) + 32'(out_valid_o), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got=running expected=done");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, f0, l0, p0;
        bit seen;
        rst_i = 1; clr_i = 0; enable_i = 0; threshold_i = '0; timeout_i = '0;
        out_ready_i = 1; push_req = 0; pop_pend = 0;
        drive_fifo();
        @(posedge clk);
        #1;
        tick();
        tick();

        // Reset state
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_rready", 32'(fifo_rready_o), 32'd0);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_data", 32'(out_data_o), 32'd0);
        check("rst_first", 32'(out_first_o), 32'd0);
        check("rst_last", 32'(out_last_o), 32'd0);
        rst_i = 0;

        // Threshold start: three words, threshold 3
        enable_i = 1; threshold_i = 3; timeout_i = 0; out_ready_i = 1;
        w0 = acc_words; f0 = acc_firsts; l0 = acc_lasts;
        push_word(16'h000A);
        push_word(16'h000B);
        push_word(16'h000C);
        wait_quiet("thr_drain", 20);
        check("thr_words", 32'(acc_words - w0), 32'd3);
        check("thr_firsts", 32'(acc_firsts - f0), 32'd1);
        check("thr_lasts", 32'(acc_lasts - l0), 32'd1);

        // Burst cap: six words preloaded, threshold 1
        enable_i = 0; threshold_i = 1;
        for (int i = 0; i < 6; i++) push_word(16'h1100 + 16'(i));
        w0 = acc_words; f0 = acc_firsts; l0 = acc_lasts;
        enable_i = 1;
        wait_quiet("cap_drain", 30);
        check("cap_words", 32'(acc_words - w0), 32'd6);
        check("cap_firsts", 32'(acc_firsts - f0), 32'd2);
        check("cap_lasts", 32'(acc_lasts - l0), 32'd2);

        // Timeout start: one word, timeout 5
        threshold_i = 0; timeout_i = 5; rise_cyc = -1000;
        push_word(16'h2222);
        wait_quiet("to_drain", 20);
        check("to_latency", 32'(rise_cyc - nonempty_cyc), 32'd6);

        // Backpressure mid-burst
        threshold_i = 4; timeout_i = 0;
        w0 = acc_words;
        for (int i = 0; i < 4; i++) push_word(16'h3300 + 16'(i));
        for (int i = 0; i < 10 && !out_valid_o; i++) tick();
        tick();
        out_ready_i = 0;
        repeat (3) tick();
        out_ready_i = 1;
        wait_quiet("bp_drain", 20);
        check("bp_words", 32'(acc_words - w0), 32'd4);

        // Clear after two pops, then restart
        p0 = pops;
        for (int i = 0; i < 4; i++) push_word(16'h4400 + 16'(i));
        for (int i = 0; i < 20 && pops - p0 < 2; i++) tick();
        clr_i = 1;
        tick();
        clr_i = 0;
        check("clr_busy", 32'(busy_o), 32'd0);
        check("clr_valid", 32'(out_valid_o), 32'd0);
        check("clr_rready", 32'(fifo_rready_o), 32'd0);
        push_word(16'h4410);
        push_word(16'h4411);
        wait_quiet("clr_restart", 20);

        // Disabled with a full FIFO
        enable_i = 0; threshold_i = 3; timeout_i = 5;
        for (int i = 0; i < 8; i++) push_word(16'h5500 + 16'(i));
        repeat (10) tick();
        check("dis_timer", 32'(dut.timer_q), 32'd0);
        enable_i = 1;
        seen = 0;
        for (int i = 0; i < 2 && !seen; i++) begin
            tick();
            seen = busy_o;
        end
        check("en_start", 32'(seen), 32'd1);
        threshold_i = 1;
        wait_quiet("dis_drain", 40);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if (c % 64 == 0) begin
                threshold_i = DW'($urandom_range(0, 7));
                timeout_i   = TW'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 49) == 0) enable_i = ~enable_i;
            out_ready_i = ($urandom_range(0, 3) != 0);
            clr_i       = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 1) == 1) begin
                push_req  = 1;
                push_data = W'($urandom);
            end
            tick();
        end
        clr_i = 0; enable_i = 1; threshold_i = 1; timeout_i = 1; out_ready_i = 1;
        wait_quiet("final_drain", 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prim_fifo_burst_reader.md
# prim_fifo_burst_reader

Read-side companion to the synchronous valid/ready FIFO. It watches the FIFO's occupancy and decides when to drain it, then pops a bounded burst of words and re-emits them through a registered valid/ready output stage. Each emitted word carries `first`/`last` framing. A burst starts when occupancy reaches a programmable threshold, or when a non-empty FIFO has waited a programmable number of cycles. It sits between the FIFO read port and a downstream consumer that prefers framed bursts, such as a bus master or serializer.

## Interface
- `Width`, 16, data word width
- `DepthW`, 3, width of the FIFO occupancy input
- `MaxBurst`, 4, maximum words per burst; must be ≥1 and ≤ FIFO depth
- `TimeoutW`, 8, width of the timeout counter and input

One clock; reset is synchronous and active-high.
- `clk_i` in 1: clock; all state updates on the rising edge
- `rst_i` in 1: synchronous active-high reset
- `clr_i` in 1: synchronous soft clear; aborts any burst
- `enable_i` in 1: allows new bursts to start
- `threshold_i` in DepthW: occupancy start threshold; 0 = disabled
- `timeout_i` in TimeoutW: idle-wait start limit in cycles; 0 = disabled
- `fifo_rvalid_i` in 1: FIFO has a word
- `fifo_rready_o` out 1: pop request to FIFO
- `fifo_rdata_i` in Width: FIFO head word
- `fifo_depth_i` in DepthW: FIFO occupancy
- `out_valid_o` out 1: output word valid
- `out_ready_i` in 1: downstream accepts
- `out_data_o` out Width: output word
- `out_first_o` out 1: word is first of its burst
- `out_last_o` out 1: word is last of its burst
- `busy_o` out 1: state is BURST

## Operation
- States: IDLE and BURST. Registers:
  - `fetch_left`, width $clog2(MaxBurst+1): words still to pop
  - `timer`, TimeoutW
  - one output register holding data, first and last
- Start condition, evaluated only in IDLE: `enable_i` & `fifo_depth_i`≠0 & (A | B).
  - A: `threshold_i`≠0 & `fifo_depth_i` ≥ `threshold_i`
  - B: `timeout_i`≠0 & `timer` ≥ `timeout_i`
  - With both disabled, no burst ever starts.
- Timer in IDLE:
  - Increments, saturating at all-ones, while `enable_i` & `fifo_depth_i`≠0.
  - Otherwise zeroed.
  - Zeroed on entry to BURST.
- On start: latch L = min(`fifo_depth_i`, MaxBurst) into `fetch_left`, then go to BURST.
- Pop rule: `fifo_rready_o` = BURST & `fetch_left`≠0 & (!`out_valid_o` | `out_ready_i`) & !`clr_i`.
- A pop is `fifo_rvalid_i` & `fifo_rready_o`. On a pop:
  - The output register loads `fifo_rdata_i`.
  - `first` = (this is the first pop of the burst).
  - `last` = (`fetch_left`==1).
  - `fetch_left` decrements.
  - `out_valid_o` is set.
- Output register behaviour:
  - Holds stable while `out_valid_o` & !`out_ready_i`.
  - Clears valid when accepted with no simultaneous pop.
- BURST → IDLE when a word with `last`=1 is accepted (`out_valid_o` & `out_ready_i`).
- `enable_i` falling during BURST does not abort it.
- If `fifo_rvalid_i` drops mid-burst (the FIFO was externally cleared), the block stalls in BURST until data arrives or `clr_i` is asserted.
- Width rules:
  - Compare `fifo_depth_i` against `threshold_i` unsigned at DepthW bits.
  - Compute min() at max(DepthW, $clog2(MaxBurst+1)) bits.

## Timing
- Reset values: state IDLE, `fifo_rready_o`=0, `out_valid_o`=0, `out_data_o`=0, `out_first_o`=0, `out_last_o`=0, `busy_o`=0, timer=0, `fetch_left`=0.
- `clr_i` has the same effect as reset but is lower priority than `rst_i`. A pop in the same cycle is suppressed.
- Start condition true in cycle N → `busy_o` and first `fifo_rready_o` in N+1 → first `out_valid_o` in N+2.
- Throughput: one word per cycle with `out_ready_i` held high. L words are emitted in cycles N+2 … N+L+1.
- Minimum gap between bursts:
  - The last accept in cycle M returns the state to IDLE in M+1.
  - The next start decision can occur in M+1, so the next `busy_o` is at the earliest in M+2.
- Timer semantics: timeout T starts a burst on the T-th cycle after the FIFO became non-empty (timer==T).

## Test plan
- Threshold start:
  - Stimulus: threshold=3, timeout=0, push 3 words A,B,C.
  - Response: depth reaches 3 in cycle N; `out_valid_o` from N+2; words A,B,C with first on A and last on C; `busy_o` low in the cycle after C is accepted.
- Burst cap:
  - Stimulus: MaxBurst=4, threshold=1, FIFO preloaded with 6 words.
  - Response: first burst carries 4 words (last on word 4); second burst carries 2 words; first is asserted on words 1 and 5.
- Timeout start:
  - Stimulus: threshold=0, timeout=5, push 1 word, out_ready=1.
  - Response: single-word burst with first=last=1; `busy_o` rises 6 cycles after depth becomes 1.
- Backpressure:
  - Stimulus: 4-word burst with `out_ready_i` low for 3 cycles mid-burst.
  - Response: data/first/last stable while stalled; `fifo_rready_o`=0 while valid and not ready; no word lost or duplicated.
- Clear mid-burst:
  - Stimulus: assert `clr_i` after 2 of 4 words are popped.
  - Response: next cycle IDLE with `out_valid_o`=0 and `fifo_rready_o`=0; no pop during the clr cycle; a new burst restarts normally.
- Disabled:
  - Stimulus: `enable_i`=0 with FIFO full.
  - Response: `fifo_rready_o` never asserts and timer stays 0; raising enable starts a burst within 2 cycles.
